pipe_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage core. Merges per-stage stall requests into the

---
 rtl/pipe_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ------------------------------------------------------------------------------------------------
// pipe_ctrl
//   Central pipeline controller for the 5-stage core.
//   - Merges per-stage stall requests into stalled_o and raises flush_o for a taken branch.
//   - Sequences machine-mode trap entry (exception or interrupt) and mret with a small FSM:
//     flush, mepc/mcause CSR writes, then PC redirect.
//   - Watchdog flags a pipeline that stays stalled for STALL_TIMEOUT consecutive cycles.
//   Stage bit map for stalled_o/flush_o: 0=pc, 1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb, 5=wb.
//
// Ports
//   clk, rst                 core clock, asynchronous active-high reset
//   stallreq_{if,id,ex,mem}_i per-stage stall requests
//   ex_branch_flag_i         branch/jump taken in ex
//   excp_req_i/cause/pc      synchronous exception from mem with its mcause and pc
//   mret_i                   mret reached mem
//   irq_i, irq_pc_i          level interrupt and its resume pc
//   mstatus_mie_i            global interrupt enable
//   mtvec_i, mepc_i          trap vector base, current mepc
//   stalled_o, flush_o       pipeline register control vectors
//   pc_load_o, new_pc_o      PC redirect
//   csr_we_o/waddr/wdata     CSR write port
//   trap_enter_o             pulse: csr unit does MPIE<=MIE, MIE<=0
//   trap_busy_o              FSM not idle
//   stall_timeout_o          sticky watchdog flag
// ------------------------------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        ex_branch_flag_i,
    input  logic        excp_req_i,
    input  logic [31:0] excp_cause_i,
    input  logic [31:0] excp_pc_i,
    input  logic        mret_i,
    input  logic        irq_i,
    input  logic [31:0] irq_pc_i,
    input  logic        mstatus_mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic [5:0]  stalled_o,
    output logic [5:0]  flush_o,
    output logic        pc_load_o,
    output logic [31:0] new_pc_o,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        trap_enter_o,
    output logic        trap_busy_o,
    output logic        stall_timeout_o
);

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(STALL_TIMEOUT);
    localparam logic [31:0]      IrqCause   = 32'h8000000B;
    localparam logic [11:0]      AddrMepc   = 12'h341;
    localparam logic [11:0]      AddrMcause = 12'h342;

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StWrMepc,
        StWrCause,
        StJump,
        StRet
    } state_e;

    state_e           state_q;
    logic [31:0]      cause_q;
    logic [31:0]      pc_q;     // trap pc, or target mepc for mret
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;

    logic take_excp;
    logic take_irq;
    logic take_mret;
    logic any_stall;

    // mtvec alignment bits are dropped by design.
    logic unused_mtvec;
    assign unused_mtvec = ^mtvec_i[1:0];

    assign take_excp = excp_req_i;
    assign take_irq  = irq_i & mstatus_mie_i & ~stallreq_mem_i;
    assign take_mret = mret_i;
    assign any_stall = stallreq_if_i | stallreq_id_i | stallreq_ex_i | stallreq_mem_i;

    // Watchdog next count: saturates at the timeout value, clears on a stall-free cycle.
    always_comb begin
        cnt_d = '0;
        if (any_stall) begin
            cnt_d = (cnt_q == TimeoutVal) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cause_q   <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == TimeoutVal) begin
                timeout_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (take_excp) begin
                        cause_q <= excp_cause_i;
                        pc_q    <= excp_pc_i;
                        state_q <= StFlush;
                    end else if (take_irq) begin
                        cause_q <= IrqCause;
                        pc_q    <= irq_pc_i;
                        state_q <= StFlush;
                    end else if (take_mret) begin
                        pc_q    <= mepc_i;
                        state_q <= StRet;
                    end
                end
                StFlush:   state_q <= StWrMepc;
                StWrMepc:  state_q <= StWrCause;
                StWrCause: state_q <= StJump;
                StJump:    state_q <= StIdle;
                StRet:     state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stalled_o    = '0;
        flush_o      = '0;
        pc_load_o    = 1'b0;
        new_pc_o     = '0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        trap_enter_o = 1'b0;
        trap_busy_o  = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                // A cycle that accepts a trap/mret/irq leaves stall and flush low.
                if (!(take_excp || take_irq || take_mret)) begin
                    if (stallreq_mem_i) begin
                        stalled_o = 6'b011111;
                    end else if (stallreq_ex_i) begin
                        stalled_o = 6'b001111;
                    end else if (stallreq_id_i) begin
                        stalled_o = 6'b000111;
                    end else if (stallreq_if_i) begin
                        stalled_o = 6'b000011;
                    end
                    if (ex_branch_flag_i && !stallreq_ex_i && !stallreq_mem_i) begin
                        flush_o = 6'b000100;
                    end
                end
            end
            StFlush: begin
                flush_o   = 6'b011110;
                stalled_o = 6'b000001;
            end
            StWrMepc: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = AddrMepc;
                csr_wdata_o = pc_q & ~32'h3;
                stalled_o   = 6'b000001;
            end
            StWrCause: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = AddrMcause;
                csr_wdata_o = cause_q;
                stalled_o   = 6'b000001;
            end
            StJump: begin
                pc_load_o    = 1'b1;
                new_pc_o     = {mtvec_i[31:2], 2'b00};
                trap_enter_o = 1'b1;
            end
            StRet: begin
                flush_o   = 6'b011110;
                pc_load_o = 1'b1;
                new_pc_o  = pc_q;
            end
            default: ;
        endcase

        // Outputs are forced low for the whole time reset is held, even though idle decode
        // would otherwise follow the inputs.
        if (rst) begin
            stalled_o    = '0;
            flush_o      = '0;
            pc_load_o    = 1'b0;
            new_pc_o     = '0;
            csr_we_o     = 1'b0;
            csr_waddr_o  = '0;
            csr_wdata_o  = '0;
            trap_enter_o = 1'b0;
            trap_busy_o  = 1'b0;
        end
    end

    assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        ex_branch_flag_i;
    logic        excp_req_i;
    logic [31:0] excp_cause_i;
    logic [31:0] excp_pc_i;
    logic        mret_i;
    logic        irq_i;
    logic [31:0] irq_pc_i;
    logic        mstatus_mie_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic [5:0]  stalled_o;
    logic [5:0]  flush_o;
    logic        pc_load_o;
    logic [31:0] new_pc_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        trap_enter_o;
    logic        trap_busy_o;
    logic        stall_timeout_o;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(
        .STALL_TIMEOUT(1024),
        .CNT_W        (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_if_i   (stallreq_if_i),
        .stallreq_id_i   (stallreq_id_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .stallreq_mem_i  (stallreq_mem_i),
        .ex_branch_flag_i(ex_branch_flag_i),
        .excp_req_i      (excp_req_i),
        .excp_cause_i    (excp_cause_i),
        .excp_pc_i       (excp_pc_i),
        .mret_i          (mret_i),
        .irq_i           (irq_i),
        .irq_pc_i        (irq_pc_i),
        .mstatus_mie_i   (mstatus_mie_i),
        .mtvec_i         (mtvec_i),
        .mepc_i          (mepc_i),
        .stalled_o       (stalled_o),
        .flush_o         (flush_o),
        .pc_load_o       (pc_load_o),
        .new_pc_o        (new_pc_o),
        .csr_we_o        (csr_we_o),
        .csr_waddr_o     (csr_waddr_o),
        .csr_wdata_o     (csr_wdata_o),
        .trap_enter_o    (trap_enter_o),
        .trap_busy_o     (trap_busy_o),
        .stall_timeout_o (stall_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".stalled"}, 32'(stalled_o), 32'h0);
        chk({tag, ".flush"}, 32'(flush_o), 32'h0);
        chk({tag, ".pc_load"}, 32'(pc_load_o), 32'h0);
        chk({tag, ".new_pc"}, new_pc_o, 32'h0);
        chk({tag, ".csr_we"}, 32'(csr_we_o), 32'h0);
        chk({tag, ".csr_waddr"}, 32'(csr_waddr_o), 32'h0);
        chk({tag, ".csr_wdata"}, csr_wdata_o, 32'h0);
        chk({tag, ".trap_enter"}, 32'(trap_enter_o), 32'h0);
        chk({tag, ".busy"}, 32'(trap_busy_o), 32'h0);
    endtask

    initial begin
        rst              = 1'b1;
        stallreq_if_i    = 1'b0;
        stallreq_id_i    = 1'b0;
        stallreq_ex_i    = 1'b0;
        stallreq_mem_i   = 1'b1;
        ex_branch_flag_i = 1'b1;
        excp_req_i       = 1'b1;
        excp_cause_i     = 32'd2;
        excp_pc_i        = 32'h80000104;
        mret_i           = 1'b0;
        irq_i            = 1'b0;
        irq_pc_i         = 32'h80000122;
        mstatus_mie_i    = 1'b1;
        mtvec_i          = 32'h80000200;
        mepc_i           = 32'h80000040;

        // Outputs low while reset is held, even with active requests.
        #2;
        chk_quiet("rst");
        chk("rst.timeout", 32'(stall_timeout_o), 32'h0);
        tick();
        tick();
        stallreq_mem_i   = 1'b0;
        ex_branch_flag_i = 1'b0;
        excp_req_i       = 1'b0;
        rst              = 1'b0;
        #1;
        chk_quiet("idle");

        // Stall priority and branch flush.
        stallreq_id_i  = 1'b1;
        stallreq_mem_i = 1'b1;
        #1;
        chk("stall.id_mem", 32'(stalled_o), 32'h1f);
        tick();
        stallreq_mem_i = 1'b0;
        #1;
        chk("stall.id", 32'(stalled_o), 32'h07);
        tick();
        stallreq_id_i = 1'b0;
        stallreq_if_i = 1'b1;
        #1;
        chk("stall.if", 32'(stalled_o), 32'h03);
        tick();
        stallreq_if_i    = 1'b0;
        ex_branch_flag_i = 1'b1;
        #1;
        chk("br.flush", 32'(flush_o), 32'h04);
        chk("br.stalled", 32'(stalled_o), 32'h00);
        tick();
        stallreq_ex_i = 1'b1;
        #1;
        chk("br_ex.flush", 32'(flush_o), 32'h00);
        chk("br_ex.stalled", 32'(stalled_o), 32'h0f);
        tick();
        stallreq_ex_i    = 1'b0;
        ex_branch_flag_i = 1'b0;

        // Exception entry: T .. T+5.
        excp_req_i     = 1'b1;
        stallreq_id_i  = 1'b1;
        #1;
        chk("exc.T.stalled", 32'(stalled_o), 32'h0);
        chk("exc.T.busy", 32'(trap_busy_o), 32'h0);
        tick();
        excp_req_i    = 1'b0;
        stallreq_id_i = 1'b0;
        excp_cause_i  = 32'd7;
        #1;
        chk("exc.T1.flush", 32'(flush_o), 32'h1e);
        chk("exc.T1.stalled", 32'(stalled_o), 32'h01);
        chk("exc.T1.busy", 32'(trap_busy_o), 32'h1);
        chk("exc.T1.csr_we", 32'(csr_we_o), 32'h0);
        tick();
        chk("exc.T2.csr_we", 32'(csr_we_o), 32'h1);
        chk("exc.T2.addr", 32'(csr_waddr_o), 32'h341);
        chk("exc.T2.data", csr_wdata_o, 32'h80000104);
        chk("exc.T2.stalled", 32'(stalled_o), 32'h01);
        tick();
        chk("exc.T3.addr", 32'(csr_waddr_o), 32'h342);
        chk("exc.T3.data", csr_wdata_o, 32'h2);
        tick();
        chk("exc.T4.pc_load", 32'(pc_load_o), 32'h1);
        chk("exc.T4.new_pc", new_pc_o, 32'h80000200);
        chk("exc.T4.enter", 32'(trap_enter_o), 32'h1);
        chk("exc.T4.csr_we", 32'(csr_we_o), 32'h0);
        tick();
        chk_quiet("exc.T5");

        // Interrupt blocked by a mem stall, then taken once it drops.
        irq_i          = 1'b1;
        stallreq_mem_i = 1'b1;
        #1;
        chk("irq.blk.stalled", 32'(stalled_o), 32'h1f);
        tick();
        chk("irq.blk.busy", 32'(trap_busy_o), 32'h0);
        stallreq_mem_i = 1'b0;
        #1;
        chk("irq.take.stalled", 32'(stalled_o), 32'h0);
        tick();
        irq_i = 1'b0;
        #1;
        chk("irq.flush", 32'(flush_o), 32'h1e);
        tick();
        chk("irq.mepc", csr_wdata_o, 32'h80000120);
        tick();
        chk("irq.cause", csr_wdata_o, 32'h8000000B);
        tick();
        chk("irq.new_pc", new_pc_o, 32'h80000200);
        tick();

        // Interrupts masked: never taken.
        mstatus_mie_i = 1'b0;
        irq_i         = 1'b1;
        tick();
        tick();
        chk("irq.masked.busy", 32'(trap_busy_o), 32'h0);
        irq_i         = 1'b0;
        mstatus_mie_i = 1'b1;

        // mret.
        mret_i = 1'b1;
        #1;
        chk("mret.T.flush", 32'(flush_o), 32'h0);
        tick();
        mret_i = 1'b0;
        mepc_i = 32'h12345678;
        #1;
        chk("mret.flush", 32'(flush_o), 32'h1e);
        chk("mret.pc_load", 32'(pc_load_o), 32'h1);
        chk("mret.new_pc", new_pc_o, 32'h80000040);
        chk("mret.stalled", 32'(stalled_o), 32'h0);
        chk("mret.csr_we", 32'(csr_we_o), 32'h0);
        tick();
        chk_quiet("mret.done");

        // Reset in WR_MEPC aborts the sequence.
        excp_req_i = 1'b1;
        tick();
        excp_req_i = 1'b0;
        tick();
        chk("abort.pre.csr_we", 32'(csr_we_o), 32'h1);
        rst = 1'b1;
        #1;
        chk_quiet("abort.rst");
        tick();
        rst = 1'b0;
        #1;
        chk_quiet("abort.idle");
        tick();
        chk("abort.no_cause", 32'(csr_we_o), 32'h0);
        chk("abort.busy", 32'(trap_busy_o), 32'h0);

        // Watchdog.
        stallreq_ex_i = 1'b1;
        for (int i = 0; i < 1023; i++) tick();
        chk("wd.1023", 32'(stall_timeout_o), 32'h0);
        tick();
        chk("wd.1024", 32'(stall_timeout_o), 32'h1);
        stallreq_ex_i = 1'b0;
        tick();
        tick();
        chk("wd.sticky", 32'(stall_timeout_o), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
